fifo_read_stage: RTL and testbench

FIFO_READ_STAGE -- requirements
Module: fifo_read_stage

---
 rtl/fifo_read_stage_pkg.sv | 11 +
 rtl/fifo_read_skid_buf.sv | 42 ++++
 rtl/fifo_read_stage.sv | 108 ++++++++++
 tb/tb_fifo_read_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_stage_pkg.sv
// Shared NoC FIFO definitions: output-buffer depth and packet-tracker state.
package fifo_read_stage_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic {
    HEADER = 1'b0,
    BODY   = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/fifo_read_skid_buf.sv
// Two-entry in-order output buffer with occupancy count; storage itself is not reset.
module fifo_read_skid_buf
  import fifo_read_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            count
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [1:0]            count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) tail_q <= tail_q + PTR_W'(1);
      if (rd_en) head_q <= head_q + PTR_W'(1);
      count_q <= count_q + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tail_q] <= wr_data;
  end

  assign rd_data = mem[head_q];
  assign count   = count_q;

endmodule

// File: rtl/fifo_read_stage.sv
// FIFO read stage: issues storage reads, absorbs the one-cycle read latency in a
// two-entry buffer, and optionally marks packet ends (macro FIFO_READ_STAGE_LAST_EN).
module fifo_read_stage
  import fifo_read_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_LSB    = 0,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty_in,
  output logic                  rd_en_out,
  input  logic [DATA_WIDTH-1:0] rdata_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  last_out,
  output logic [1:0]            count_out
);

  if (LEN_LSB + LEN_WIDTH > DATA_WIDTH) begin : g_len_check
    $error("length field exceeds flit width");
  end

  // Handshake: a flit transfers in any cycle where valid_out && ready_in; once
  // valid_out is high, data_out stays put until that transfer happens.
  logic       inflight_q;
  logic       run_q;
  logic       pop;
  logic [1:0] count;
  logic [2:0] occ;

  assign valid_out = (count != 2'd0);
  assign pop       = valid_out & ready_in;
  assign occ       = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  // run_q keeps reads off until the first edge after reset release.
  assign rd_en_out = run_q & ~empty_in & (occ < 3'(BUF_DEPTH));
  assign count_out = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      inflight_q <= rd_en_out;
      run_q      <= 1'b1;
    end
  end

  fifo_read_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (inflight_q),
    .wr_data(rdata_in),
    .rd_en  (pop),
    .rd_data(data_out),
    .count  (count)
  );

`ifdef FIFO_READ_STAGE_LAST_EN
  pkt_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic                 is_last;

  assign hdr_len = data_out[LEN_LSB +: LEN_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HEADER;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // A header length of 0 or 1 is a single-flit packet.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    is_last = (state_q == HEADER) ? (hdr_len <= LEN_WIDTH'(1)) : (rem_q == LEN_WIDTH'(1));
    if (pop) begin
      case (state_q)
        HEADER: begin
          if (hdr_len > LEN_WIDTH'(1)) begin
            rem_d   = hdr_len - LEN_WIDTH'(1);
            state_d = BODY;
          end
        end
        BODY: begin
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = HEADER;
        end
        default: state_d = HEADER;
      endcase
    end
  end

  assign last_out = valid_out & is_last;
`else
  assign last_out = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_stage.sv
// Directed bench for fifo_read_stage: models the storage/read-pointer side and
// scoreboards every popped flit against the flits offered.
module tb_fifo_read_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        empty_in;
  logic        rd_en_out;
  logic [31:0] rdata_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        last_out;
  logic [1:0]  count_out;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  logic        check_last;
  logic        rd_seen;
  logic        pop_seen;
  int          total;
  int          bad;

`ifdef FIFO_READ_STAGE_LAST_EN
  localparam int EXP_LAST_PULSES = 2;
`else
  localparam int EXP_LAST_PULSES = 0;
`endif

  fifo_read_stage dut (
    .clk      (clk),
    .rst      (rst),
    .empty_in (empty_in),
    .rd_en_out(rd_en_out),
    .rdata_in (rdata_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .last_out (last_out),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic push_flit(input logic [31:0] v, input logic l);
    src_q.push_back(v);
    exp_q.push_back(v);
    exp_last_q.push_back(l);
    empty_in = 1'b0;
  endtask

  // Scoreboard: observe at the falling edge, compare each popped flit.
  task automatic sample();
    logic [31:0] exp_d;
    logic        exp_l;
    @(negedge clk);
    rd_seen  = rd_en_out;
    pop_seen = valid_out && ready_in;
    if (pop_seen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got data %h, required no flit", data_out);
      end else begin
        exp_d = exp_q.pop_front();
        exp_l = exp_last_q.pop_front();
        if (data_out !== exp_d) begin
          bad++;
          $display("FAIL pop_data: got %h, required %h", data_out, exp_d);
        end
`ifdef FIFO_READ_STAGE_LAST_EN
        if (check_last) begin
          total++;
          if (last_out !== exp_l) begin
            bad++;
            $display("FAIL pop_last: got %b, required %b (data %h)", last_out, exp_l, exp_d);
          end
        end
`endif
      end
    end
`ifndef FIFO_READ_STAGE_LAST_EN
    total++;
    if (last_out !== 1'b0) begin
      bad++;
      $display("FAIL last_tied_low: got %b, required 0", last_out);
    end
`endif
  endtask

  // Storage model: a read request returns its flit in the following cycle.
  task automatic advance();
    @(posedge clk);
    #1;
    if (rd_seen) begin
      if (src_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_on_empty: got rd_en_out=1, required 0 with storage empty");
        rdata_in = $urandom();
      end else begin
        rdata_in = src_q.pop_front();
      end
    end else begin
      rdata_in = $urandom();
    end
    empty_in = (src_q.size() == 0);
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic test_reset();
    rst = 1'b0; empty_in = 1'b0; ready_in = 1'b1; rdata_in = '0; rd_seen = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 4;
    if (rd_en_out !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b, required 0", rd_en_out); end
    if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", valid_out); end
    if (last_out !== 1'b0) begin bad++; $display("FAIL reset_last: got %b, required 0", last_out); end
    if (count_out !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d, required 0", count_out); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (rd_en_out !== 1'b0) begin bad++; $display("FAIL release_rd_en: got %b, required 0 before first edge", rd_en_out); end
    empty_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    ready_in = 1'b0;
    push_flit(32'h0000_00A5, 1'b0);
    sample();
    total += 2;
    if (rd_en_out !== 1'b1) begin bad++; $display("FAIL single_rd_t: got %b, required 1", rd_en_out); end
    if (valid_out !== 1'b0) begin bad++; $display("FAIL single_valid_t: got %b, required 0", valid_out); end
    advance();
    sample();
    total += 2;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL single_valid_t1: got %b, required 0", valid_out); end
    if (rd_en_out !== 1'b0) begin bad++; $display("FAIL single_rd_t1: got %b, required 0", rd_en_out); end
    advance();
    sample();
    total += 3;
    if (valid_out !== 1'b1) begin bad++; $display("FAIL single_valid_t2: got %b, required 1", valid_out); end
    if (data_out !== 32'h0000_00A5) begin bad++; $display("FAIL single_data_t2: got %h, required 000000a5", data_out); end
    if (count_out !== 2'd1) begin bad++; $display("FAIL single_count_t2: got %0d, required 1", count_out); end
    advance();
    sample();
    total += 2;
    if (valid_out !== 1'b1) begin bad++; $display("FAIL single_hold_valid: got %b, required 1", valid_out); end
    if (data_out !== 32'h0000_00A5) begin bad++; $display("FAIL single_hold_data: got %h, required 000000a5", data_out); end
    advance();
    ready_in = 1'b1;
    tick();
    sample();
    total += 2;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL single_after_pop_valid: got %b, required 0", valid_out); end
    if (count_out !== 2'd0) begin bad++; $display("FAIL single_after_pop_count: got %0d, required 0", count_out); end
    advance();
  endtask

  task automatic test_stream();
    logic [11:0] rd_pat;
    logic [11:0] pop_pat;
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) push_flit(32'h0000_0100 + i * 32'h0101_0101, 1'b0);
    rd_pat = '0; pop_pat = '0;
    for (int i = 0; i < 12; i++) begin
      sample();
      rd_pat[i]  = rd_seen;
      pop_pat[i] = pop_seen;
      advance();
    end
    total += 3;
    if (rd_pat !== 12'h0FF) begin bad++; $display("FAIL stream_rd_pattern: got %h, required 0ff", rd_pat); end
    if (pop_pat !== 12'h3FC) begin bad++; $display("FAIL stream_pop_pattern: got %h, required 3fc", pop_pat); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL stream_leftover: got %0d flits pending, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int          reads;
    logic [31:0] held;
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) push_flit(32'hB000_0000 + i, 1'b0);
    reads = 0; held = '0;
    for (int i = 0; i < 6; i++) begin
      sample();
      reads += int'(rd_seen);
      if (i == 3) held = data_out;
      advance();
    end
    sample();
    reads += int'(rd_seen);
    total += 5;
    if (reads != 2) begin bad++; $display("FAIL bp_reads: got %0d, required 2", reads); end
    if (count_out !== 2'd2) begin bad++; $display("FAIL bp_count: got %0d, required 2", count_out); end
    if (valid_out !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b, required 1", valid_out); end
    if (data_out !== 32'hB000_0000) begin bad++; $display("FAIL bp_head: got %h, required b0000000", data_out); end
    if (data_out !== held) begin bad++; $display("FAIL bp_hold: got %h, required %h", data_out, held); end
    advance();
    ready_in = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain: got %0d flits missing, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int stale;
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) push_flit(32'hC000_0000 + i, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    @(negedge clk);
    total += 4;
    if (rd_en_out !== 1'b0) begin bad++; $display("FAIL rmid_rd_en: got %b, required 0", rd_en_out); end
    if (valid_out !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b, required 0", valid_out); end
    if (last_out !== 1'b0) begin bad++; $display("FAIL rmid_last: got %b, required 0", last_out); end
    if (count_out !== 2'd0) begin bad++; $display("FAIL rmid_count: got %0d, required 0", count_out); end
    src_q.delete(); exp_q.delete(); exp_last_q.delete();
    empty_in = 1'b1; rd_seen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; ready_in = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      stale += int'(valid_out);
      advance();
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL rmid_stale: got %0d valid cycles, required 0", stale); end
  endtask

  task automatic test_packet();
    int lasts;
    check_last = 1'b1;
    ready_in   = 1'b1;
    push_flit(32'hAB00_0003, 1'b0);
    push_flit(32'h1111_1110, 1'b0);
    push_flit(32'h2222_2220, 1'b1);
    push_flit(32'hCD00_0001, 1'b1);
    lasts = 0;
    for (int i = 0; i < 12; i++) begin
      sample();
      lasts += int'(last_out);
      advance();
    end
    total += 2;
    if (lasts != EXP_LAST_PULSES) begin bad++; $display("FAIL pkt_last_count: got %0d, required %0d", lasts, EXP_LAST_PULSES); end
    if (exp_q.size() != 0) begin bad++; $display("FAIL pkt_drain: got %0d flits missing, required 0", exp_q.size()); end
  endtask

  initial begin
    total = 0; bad = 0; check_last = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
